// File: rtl/write_pointer_full_block.sv
// Write-side pointer, full and occupancy logic for an asynchronous FIFO.
// Latency: write_accept_o is combinational; pointer, full, almost-full, level and overflow are registered (1 cycle).
// Backpressure: writes are refused while write_full_o is high; a refused write sets the sticky overflow flag.
//
// Ports:
//   write_clock_i           write-domain clock
//   write_reset_i           asynchronous active-high reset
//   write_enable_i          producer write request
//   write_overflow_clear_i  synchronous clear of the sticky overflow flag
//   read_to_write_pointer_i Gray read pointer, already synchronized into this domain
//   write_accept_o          write strobe to the FIFO memory
//   write_address_o         binary write address to the FIFO memory
//   write_pointer_o         Gray write pointer towards the read-domain synchronizer
//   write_full_o            FIFO full
//   write_almost_full_o     occupancy at or above almost_full_threshold
//   write_level_o           occupancy seen from the write domain, 0..2^addr_size
//   write_overflow_o        sticky: a write was attempted while full
module write_pointer_full_block #(
  parameter int addr_size             = 3,
  parameter int almost_full_threshold = 6
) (
  input  logic                 write_clock_i,
  input  logic                 write_reset_i,
  input  logic                 write_enable_i,
  input  logic                 write_overflow_clear_i,
  input  logic [addr_size:0]   read_to_write_pointer_i,
  output logic                 write_accept_o,
  output logic [addr_size-1:0] write_address_o,
  output logic [addr_size:0]   write_pointer_o,
  output logic                 write_full_o,
  output logic                 write_almost_full_o,
  output logic [addr_size:0]   write_level_o,
  output logic                 write_overflow_o
);

  localparam int PW = addr_size + 1;

  // Full means the write pointer is exactly one lap ahead of the read pointer;
  // in Gray code that is the read pointer with its two MSBs inverted.
  localparam logic [addr_size:0] FULL_MASK = PW'(3) << (addr_size - 1);
  localparam logic [addr_size:0] AF_TH     = PW'(almost_full_threshold);

  function automatic logic [addr_size:0] gray_to_bin(input logic [addr_size:0] g);
    logic [addr_size:0] b;
    b            = '0;
    b[addr_size] = g[addr_size];
    for (int i = addr_size - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [addr_size:0] wbin_q,     wbin_d;
  logic [addr_size:0] wgray_q,    wgray_d;
  logic               full_q,     full_d;
  logic               afull_q,    afull_d;
  logic [addr_size:0] level_q,    level_d;
  logic               overflow_q, overflow_d;
  logic [addr_size:0] rbin;
  logic               accept;

  always_comb begin
    accept     = write_enable_i & ~full_q;
    rbin       = gray_to_bin(read_to_write_pointer_i);
    wbin_d     = wbin_q + PW'(accept);
    wgray_d    = wbin_d ^ (wbin_d >> 1);
    full_d     = (wgray_d == (read_to_write_pointer_i ^ FULL_MASK));
    level_d    = wbin_d - rbin;
    afull_d    = (level_d >= AF_TH);
    overflow_d = overflow_q;
    // Set wins over a coincident clear.
    if (write_enable_i && full_q) begin
      overflow_d = 1'b1;
    end else if (write_overflow_clear_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge write_clock_i or posedge write_reset_i) begin
    if (write_reset_i) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  assign write_accept_o      = accept;
  assign write_address_o     = wbin_q[addr_size-1:0];
  assign write_pointer_o     = wgray_q;
  assign write_full_o        = full_q;
  assign write_almost_full_o = afull_q;
  assign write_level_o       = level_q;
  assign write_overflow_o    = overflow_q;

endmodule

// File: doc/write_pointer_full_block.md
WRITE_POINTER_FULL_BLOCK -- requirements
Module: write_pointer_full_block

Interface
REQ-001 The block SHALL have parameter addr_size, default 3, giving the FIFO address width (depth 2^addr_size).
REQ-002 The block SHALL have parameter almost_full_threshold, default 6, giving the level at or above which almost-full asserts; valid range 1..2^addr_size.
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-004 write_clock_i  input  1  write-domain clock; all state updates on its rising edge.
REQ-005 write_reset_i  input  1  asynchronous active-high reset.
REQ-006 write_enable_i  input  1  write request from the producer.
REQ-007 write_overflow_clear_i  input  1  synchronous clear of the sticky overflow flag.
REQ-008 read_to_write_pointer_i  input  addr_size+1  Gray-coded read pointer, already synchronized into the write domain.
REQ-009 write_accept_o  output  1  combinational, write_enable_i AND NOT write_full_o; write strobe to FIFO memory.
REQ-010 write_address_o  output  addr_size  binary write address to FIFO memory, the low addr_size bits of the binary write pointer.
REQ-011 write_pointer_o  output  addr_size+1  registered Gray-coded write pointer, sent to the write-to-read synchronizer.
REQ-012 write_full_o  output  1  registered full flag.
REQ-013 write_almost_full_o  output  1  registered almost-full flag.
REQ-014 write_level_o  output  addr_size+1  registered occupancy as seen from the write domain, range 0..2^addr_size.
REQ-015 write_overflow_o  output  1  registered sticky flag; a write was attempted while full.

Function
REQ-016 The block SHALL hold a binary write pointer wbin of addr_size+1 bits, and write_pointer_o SHALL equal the registered Gray value of wbin, where gray = bin XOR (bin >> 1).
REQ-017 On a rising edge with write_accept_o = 1, wbin SHALL increment by 1 modulo 2^(addr_size+1); otherwise wbin SHALL hold.
REQ-018 write_address_o and write_pointer_o SHALL update on the same edge that consumes the accepted write; the memory write uses the pre-edge address.
REQ-019 The next full value SHALL equal 1 exactly when the next Gray write pointer equals read_to_write_pointer_i with its two MSBs inverted and its remaining bits unchanged; it SHALL be registered into write_full_o.
REQ-020 The block SHALL convert read_to_write_pointer_i to binary rbin by prefix XOR from the MSB downward.
REQ-021 The next level SHALL equal (next wbin - rbin) modulo 2^(addr_size+1) and SHALL be registered into write_level_o.
REQ-022 The next almost-full value SHALL equal 1 when the next level is >= almost_full_threshold, and SHALL be registered into write_almost_full_o.
REQ-023 Full, almost-full and level SHALL reflect a change on read_to_write_pointer_i at the first rising edge after the change; the block SHALL add no further synchronization stages.
REQ-024 A write_enable_i while write_full_o = 1 SHALL leave the pointer unchanged, drive write_accept_o = 0, and set write_overflow_o at that edge.
REQ-025 write_overflow_clear_i SHALL clear write_overflow_o at the edge; if a set condition coincides with a clear, set SHALL win.
REQ-026 A write in the same cycle that the synchronized read pointer advances SHALL be judged against the current write_full_o; full deasserts only through a read pointer change.
REQ-027 Wrap-around of wbin from 2^(addr_size+1)-1 to 0 SHALL produce correct Gray, full and level values with no special case.

Reset
REQ-028 While write_reset_i = 1, the block SHALL hold wbin, write_pointer_o, write_address_o, write_full_o, write_almost_full_o, write_level_o and write_overflow_o at 0, immediately and independent of the clock, including mid-operation.
REQ-029 The first edge after reset deassertion SHALL be able to accept a write.

Verification (addr_size = 3, almost_full_threshold = 6)
REQ-030 Assert reset between clock edges after 5 writes -> all registered outputs go to 0 before the next edge.
REQ-031 Read pointer 0000, 8 consecutive writes -> write_pointer_o = 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100; almost-full asserts after the 6th write; full = 1 and level = 8 after the 8th write.
REQ-032 Full, then write_enable_i = 1 for 2 cycles -> write_accept_o = 0, pointer stays 1100, overflow = 1; then clear = 1 for one cycle -> overflow = 0.
REQ-033 Full, then read_to_write_pointer_i changes to 0001 -> at the next edge full = 0 and level = 7; almost-full stays 1.
REQ-034 Read pointer 1100 (bin 8), wbin stepped from 8 through 15 to 0 -> full asserts exactly when wbin wraps to 0 (Gray 0000), level = 8.
REQ-035 Full, with write_enable_i and write_overflow_clear_i both 1 in the same cycle -> overflow remains 1.
